// File: rtl/prize_grid_if.sv
// prize_grid_if: pixel lookup, collision and level-load signals between the VGA/game path and prize_grid_manager.
interface prize_grid_if #(
  parameter int ROWS = 7,
  parameter int COLS = 10,
  parameter int NUM_LVLS = 4,
  parameter int TYPE_W = 3
);
  localparam int LW = NUM_LVLS > 1 ? $clog2(NUM_LVLS) : 1;
  localparam int CW = $clog2(ROWS * COLS + 1);
  logic [10:0] pixelX, pixelY, bumpy_x, bumpy_y, tileTopLeftX, tileTopLeftY;
  logic startOfFrame, collision, load_lvl, collected, level_clear, busy;
  logic [9:0] random_prize;
  logic [LW-1:0] lvl;
  logic [TYPE_W-1:0] prize_type, collected_type;
  logic [1:0] random_prize_color;
  logic [CW-1:0] prizes_left;
  modport master (
    output pixelX, pixelY, startOfFrame, collision, bumpy_x, bumpy_y, random_prize, lvl, load_lvl,
    input prize_type, tileTopLeftX, tileTopLeftY, random_prize_color, collected, collected_type,
    prizes_left, level_clear, busy
  );
  modport slave (
    input pixelX, pixelY, startOfFrame, collision, bumpy_x, bumpy_y, random_prize, lvl, load_lvl,
    output prize_type, tileTopLeftX, tileTopLeftY, random_prize_color, collected, collected_type,
    prizes_left, level_clear, busy
  );
endinterface

// File: rtl/prize_grid_manager.sv
// prize_grid_manager: per-level prize tile map with pixel lookup, collision clearing and score pulses.
// Optional PRIZE_RESPAWN_EN: one pending slot respawns the last collected prize after RESPAWN_FRAMES frames.
module prize_grid_manager #(
  parameter int ROWS = 7,
  parameter int COLS = 10,
  parameter int TILE_LOG2 = 6,
  parameter int NUM_LVLS = 4,
  parameter int TYPE_W = 3,
  parameter int RESPAWN_FRAMES = 240
) (
  input logic clk,
  input logic resetN,
  prize_grid_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int LW = NUM_LVLS > 1 ? $clog2(NUM_LVLS) : 1;
  localparam int XW = 11 - TILE_LOG2;
  typedef enum logic {LOAD, RUN} state_t;
  state_t r_state;
  logic [TYPE_W-1:0] r_map [N];
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_lvl;
  logic [XW-1:0] w_pc, w_pr, w_bc, w_br;
  logic w_pin, w_bin, w_hit, w_rs, w_unused;
  logic [IW-1:0] w_pidx, w_bidx;
  logic [TYPE_W-1:0] w_pval, w_bval, w_ld;
  logic [LW-1:0] w_lvl;
  function automatic logic [TYPE_W-1:0] lvl_cell(int l, int r, int c);
    return l == 0 ? ((r == 1 && c == 0) ? TYPE_W'(1) : '0) :
           l == 1 ? (r == 1 ? TYPE_W'(1) : '0) :
           l == 2 ? ((r == 1 || r == 3) ? TYPE_W'(2) : '0) :
                    (r == c ? TYPE_W'(3) : '0);
  endfunction
  always_comb begin
    w_pc = bus.pixelX[10:TILE_LOG2];
    w_pr = bus.pixelY[10:TILE_LOG2];
    w_bc = bus.bumpy_x[10:TILE_LOG2];
    w_br = bus.bumpy_y[10:TILE_LOG2];
    w_pin = int'(w_pc) < COLS && int'(w_pr) < ROWS;
    w_bin = int'(w_bc) < COLS && int'(w_br) < ROWS;
    w_pidx = IW'(int'(w_pr) * COLS + int'(w_pc));
    w_bidx = IW'(int'(w_br) * COLS + int'(w_bc));
    w_pval = w_pin ? r_map[w_pidx] : '0;
    w_bval = w_bin ? r_map[w_bidx] : '0;
    w_lvl = int'(bus.lvl) >= NUM_LVLS ? LW'(NUM_LVLS - 1) : bus.lvl;
    w_ld = lvl_cell(int'(r_lvl), int'(r_idx) / COLS, int'(r_idx) % COLS);
    w_hit = r_state == RUN && bus.collision && !bus.load_lvl && w_bval != '0;
  end
`ifdef PRIZE_RESPAWN_EN
  localparam int RW = RESPAWN_FRAMES > 1 ? $clog2(RESPAWN_FRAMES) : 1;
  logic r_rs_v;
  logic [IW-1:0] r_rs_idx;
  logic [TYPE_W-1:0] r_rs_t;
  logic [RW-1:0] r_rs_cnt;
  assign w_rs = r_rs_v && bus.startOfFrame && r_rs_cnt == RW'(RESPAWN_FRAMES - 1) && r_state == RUN &&
                !bus.load_lvl && !w_hit;
  assign w_unused = ^{bus.bumpy_x[TILE_LOG2-1:0], bus.bumpy_y[TILE_LOG2-1:0]};
  // A collection that empties the level leaves nothing to respawn.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_rs_v <= 1'b0;
      r_rs_idx <= '0;
      r_rs_t <= '0;
      r_rs_cnt <= '0;
    end else if (bus.load_lvl) r_rs_v <= 1'b0;
    else if (w_hit) begin
      r_rs_v <= bus.prizes_left != CW'(1);
      r_rs_idx <= w_bidx;
      r_rs_t <= w_bval;
      r_rs_cnt <= '0;
    end else if (w_rs) r_rs_v <= 1'b0;
    else if (r_rs_v && bus.startOfFrame) r_rs_cnt <= r_rs_cnt + RW'(1);
`else
  assign w_rs = 1'b0;
  assign w_unused = ^{bus.bumpy_x[TILE_LOG2-1:0], bus.bumpy_y[TILE_LOG2-1:0], bus.startOfFrame,
                      RESPAWN_FRAMES == 0};
`endif
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_lvl <= '0;
      for (int i = 0; i < N; i++) r_map[i] <= '0;
      bus.prize_type <= '0;
      bus.tileTopLeftX <= '0;
      bus.tileTopLeftY <= '0;
      bus.random_prize_color <= '0;
      bus.collected <= 1'b0;
      bus.collected_type <= '0;
      bus.prizes_left <= '0;
      bus.level_clear <= 1'b0;
      bus.busy <= 1'b1;
    end else begin
      bus.prize_type <= r_state == RUN ? w_pval : '0;
      bus.tileTopLeftX <= {w_pc, TILE_LOG2'(0)};
      bus.tileTopLeftY <= {w_pr, TILE_LOG2'(0)};
      bus.random_prize_color <= {bus.random_prize[4'(int'(w_pr) % 10)], bus.random_prize[4'(int'(w_pc) % 10)]};
      bus.collected <= w_hit;
      bus.level_clear <= 1'b0;
      if (w_hit) begin
        r_map[w_bidx] <= '0;
        bus.collected_type <= w_bval;
        bus.prizes_left <= bus.prizes_left - CW'(1);
        bus.level_clear <= bus.prizes_left == CW'(1);
      end else if (w_rs) begin
`ifdef PRIZE_RESPAWN_EN
        r_map[r_rs_idx] <= r_rs_t;
`endif
        bus.prizes_left <= bus.prizes_left + CW'(1);
      end
      if (bus.load_lvl) begin
        r_state <= LOAD;
        r_idx <= '0;
        r_lvl <= w_lvl;
        bus.prizes_left <= '0;
        bus.busy <= 1'b1;
      end else if (r_state == LOAD) begin
        r_map[r_idx] <= w_ld;
        bus.prizes_left <= bus.prizes_left + CW'(w_ld != '0);
        r_idx <= r_idx + IW'(1);
        if (r_idx == IW'(N - 1)) begin
          r_state <= RUN;
          bus.busy <= 1'b0;
          bus.level_clear <= bus.prizes_left == '0 && w_ld == '0;
        end
      end
    end
endmodule

// File: tb/tb_prize_grid_manager.sv
// tb_prize_grid_manager: directed checks of loading, lookup, collection and level-clear behaviour.
module tb_prize_grid_manager;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  int pulses;
  always #5 clk = ~clk;
  prize_grid_if #(.ROWS(7), .COLS(10), .NUM_LVLS(4), .TYPE_W(3)) bus ();
  prize_grid_manager dut (.clk(clk), .resetN(resetN), .bus(bus));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      step();
      cycles++;
    end
  endtask
  task automatic load(input logic [1:0] l);
    bus.lvl = l;
    bus.load_lvl = 1'b1;
    step();
    bus.load_lvl = 1'b0;
  endtask
  task automatic pix(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    step();
  endtask
  initial begin
    bus.pixelX = '0;
    bus.pixelY = '0;
    bus.bumpy_x = '0;
    bus.bumpy_y = '0;
    bus.startOfFrame = 1'b0;
    bus.collision = 1'b0;
    bus.random_prize = 10'b0000000010;
    bus.lvl = '0;
    bus.load_lvl = 1'b0;
    step();
    step();
    chk("reset_busy", 32'(bus.busy), 1);
    chk("reset_left", 32'(bus.prizes_left), 0);
    chk("reset_type", 32'(bus.prize_type), 0);
    chk("reset_collected", 32'(bus.collected), 0);
    chk("reset_clear", 32'(bus.level_clear), 0);
    resetN = 1'b1;
    for (int i = 0; i < 69; i++) step();
    chk("busy_at_69", 32'(bus.busy), 1);
    step();
    chk("busy_at_70", 32'(bus.busy), 0);
    chk("l0_left", 32'(bus.prizes_left), 1);
    pix(10, 70);
    chk("l0_type", 32'(bus.prize_type), 1);
    chk("l0_tlx", 32'(bus.tileTopLeftX), 0);
    chk("l0_tly", 32'(bus.tileTopLeftY), 64);
    chk("l0_color", 32'(bus.random_prize_color), 2);
    bus.bumpy_x = 11'd10;
    bus.bumpy_y = 11'd70;
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    chk("l0_collected", 32'(bus.collected), 1);
    chk("l0_clear", 32'(bus.level_clear), 1);
    chk("l0_left_zero", 32'(bus.prizes_left), 0);
    chk("l0_ctype", 32'(bus.collected_type), 1);
    step();
    chk("l0_collected_off", 32'(bus.collected), 0);
    chk("l0_clear_off", 32'(bus.level_clear), 0);
    load(2'd1);
    chk("l1_busy_rise", 32'(bus.busy), 1);
    wait_idle(n);
    chk("l1_load_cycles", 32'(n), 70);
    chk("l1_left", 32'(bus.prizes_left), 10);
    bus.bumpy_x = 11'd200;
    bus.bumpy_y = 11'd100;
    bus.collision = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += int'(bus.collected);
    end
    bus.collision = 1'b0;
    step();
    pulses += int'(bus.collected);
    chk("l1_pulses", 32'(pulses), 1);
    chk("l1_ctype", 32'(bus.collected_type), 1);
    chk("l1_left_dec", 32'(bus.prizes_left), 9);
    pix(200, 100);
    chk("l1_cleared_cell", 32'(bus.prize_type), 0);
    pix(260, 100);
    chk("l1_neighbour", 32'(bus.prize_type), 1);
    chk("l1_tlx", 32'(bus.tileTopLeftX), 256);
    bus.bumpy_x = 11'd10;
    bus.bumpy_y = 11'd10;
    bus.collision = 1'b1;
    step();
    chk("free_no_pulse", 32'(bus.collected), 0);
    bus.bumpy_x = 11'd700;
    bus.bumpy_y = 11'd100;
    step();
    chk("oob_no_pulse", 32'(bus.collected), 0);
    chk("oob_left", 32'(bus.prizes_left), 9);
    bus.bumpy_x = 11'd264;
    bus.bumpy_y = 11'd70;
    bus.lvl = 2'd2;
    bus.load_lvl = 1'b1;
    step();
    bus.load_lvl = 1'b0;
    bus.collision = 1'b0;
    chk("load_wins_pulse", 32'(bus.collected), 0);
    chk("load_wins_busy", 32'(bus.busy), 1);
    wait_idle(n);
    chk("l2_load_cycles", 32'(n), 70);
    chk("l2_left", 32'(bus.prizes_left), 20);
    pix(10, 200);
    chk("l2_type", 32'(bus.prize_type), 2);
    load(2'd1);
    for (int i = 0; i < 10; i++) step();
    chk("restart_busy", 32'(bus.busy), 1);
    load(2'(7));
    wait_idle(n);
    chk("restart_cycles", 32'(n), 70);
    chk("l3_left", 32'(bus.prizes_left), 7);
    pix(700, 10);
    chk("l3_oob_type", 32'(bus.prize_type), 0);
    bus.random_prize = 10'b0000000100;
    pix(128, 128);
    chk("l3_diag_type", 32'(bus.prize_type), 3);
    chk("l3_diag_tly", 32'(bus.tileTopLeftY), 128);
    chk("l3_color", 32'(bus.random_prize_color), 3);
    pix(192, 128);
    chk("l3_offdiag_type", 32'(bus.prize_type), 0);
`ifdef PRIZE_RESPAWN_EN
    load(2'd1);
    wait_idle(n);
    chk("rs_load_cycles", 32'(n), 70);
    bus.bumpy_x = 11'd0;
    bus.bumpy_y = 11'd64;
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    chk("rs_collected", 32'(bus.collected), 1);
    chk("rs_left_dec", 32'(bus.prizes_left), 9);
    for (int i = 0; i < 239; i++) begin
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
      step();
    end
    chk("rs_before", 32'(bus.prizes_left), 9);
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
    chk("rs_left_back", 32'(bus.prizes_left), 10);
    pix(0, 64);
    chk("rs_cell_back", 32'(bus.prize_type), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
